// File: rtl/modport_fifo_if.sv
// -----------------------------------------------------------------------------
// modport_fifo_if
//   Handshake bundle between a FIFO user and modport_fifo.
//   master : drives winc/wdata/rinc, observes wfull/rdata/rempty/count
//   slave  : the FIFO itself
//   Signals:
//     winc   write request            wdata  write data (WIDTH)
//     wfull  FIFO holds DEPTH words   rinc   read request
//     rdata  show-ahead head word     rempty FIFO holds 0 words
//     count  stored words, 0..DEPTH (ASIZE+1 bits)
// -----------------------------------------------------------------------------
interface modport_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ASIZE = 4
);
  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             wfull;
  logic             rinc;
  logic [WIDTH-1:0] rdata;
  logic             rempty;
  logic [ASIZE:0]   count;

  modport master (
    output winc,
    output wdata,
    output rinc,
    input  wfull,
    input  rdata,
    input  rempty,
    input  count
  );

  modport slave (
    input  winc,
    input  wdata,
    input  rinc,
    output wfull,
    output rdata,
    output rempty,
    output count
  );
endinterface

// File: rtl/modport_fifo.sv
// -----------------------------------------------------------------------------
// modport_fifo
//   Single-clock synchronous FIFO, DEPTH = 2**ASIZE words of WIDTH bits.
//   Show-ahead read port: rdata always presents the head word.
//   Ports:
//     wclk  sole clock, rising edge
//     wrst  asynchronous active-high reset; clears pointers and memory
//     bus   modport_fifo_if.slave (winc/wdata/wfull/rinc/rdata/rempty/count)
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   when the address bits coincide. Flags and count are derived only from the
//   registered pointers, so there is no combinational path from winc/rinc.
// -----------------------------------------------------------------------------
module modport_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ASIZE = 4
) (
  input logic           wclk,
  input logic           wrst,
  modport_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  // Same address, opposite lap => full; identical pointers => empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (waddr == raddr) && (wptr_q[ASIZE] != rptr_q[ASIZE]);

  // Acceptance gates use the registered flags, so a write on a full FIFO and
  // a read on an empty FIFO are dropped even when paired with the other side.
  assign wr_en = bus.winc && !full;
  assign rd_en = bus.rinc && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Memory is reset so the head word is a defined 0 straight out of reset.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr] <= bus.wdata;
    end
  end

  assign bus.rdata  = mem_q[raddr];
  assign bus.rempty = empty;
  assign bus.wfull  = full;
  // Modular difference handles pointer wrap without special cases.
  assign bus.count  = wptr_q - rptr_q;

endmodule

// File: tb/tb_modport_fifo.sv
module tb_modport_fifo;
  localparam int WIDTH = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic wclk;
  logic wrst;
  int   n_checks;
  int   n_pass;
  logic [WIDTH-1:0] model [$];

  modport_fifo_if #(.WIDTH(WIDTH), .ASIZE(ASIZE)) bus ();

  modport_fifo #(.WIDTH(WIDTH), .ASIZE(ASIZE)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  // One clock of stimulus; updates the queue model with the acceptance rules
  // (write needs room, read needs data) and reports the head seen pre-edge.
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r,
                       output logic popped, output logic [WIDTH-1:0] got,
                       output logic [WIDTH-1:0] exp);
    logic wr_ok;
    bus.winc  = w;
    bus.wdata = d;
    bus.rinc  = r;
    popped = r && (model.size() > 0);
    wr_ok  = w && (model.size() < DEPTH);
    got    = bus.rdata;
    exp    = popped ? model[0] : '0;
    @(posedge wclk);
    if (popped) void'(model.pop_front());
    if (wr_ok) model.push_back(d);
    #1;
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    bus.winc = 1'b1; bus.wdata = 8'h77; bus.rinc = 1'b1;
    repeat (2) @(posedge wclk);
    #1;
    n_checks++;
    if (bus.rempty !== 1'b1) $display("FAIL reset_rempty got=%b want=1", bus.rempty); else n_pass++;
    n_checks++;
    if (bus.wfull !== 1'b0) $display("FAIL reset_wfull got=%b want=0", bus.wfull); else n_pass++;
    n_checks++;
    if (bus.count !== 5'd0) $display("FAIL reset_count got=%0d want=0", bus.count); else n_pass++;
    bus.winc = 1'b0; bus.rinc = 1'b0;
    #2 wrst = 1'b0;
    @(posedge wclk); #1;
    n_checks++;
    if (bus.rdata !== 8'h00) $display("FAIL reset_rdata got=%h want=00", bus.rdata); else n_pass++;
    n_checks++;
    if (bus.rempty !== 1'b1 || bus.wfull !== 1'b0 || bus.count !== 5'd0)
      $display("FAIL idle_after_reset got e=%b f=%b c=%0d want e=1 f=0 c=0",
               bus.rempty, bus.wfull, bus.count);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic p; logic [WIDTH-1:0] g, e;
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) cycle(1'b1, vals[i], 1'b0, p, g, e);
    n_checks++;
    if (bus.count !== 5'd3) $display("FAIL basic_count3 got=%0d want=3", bus.count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, p, g, e);
      n_checks++;
      if (g !== vals[i]) $display("FAIL basic_read%0d got=%h want=%h", i, g, vals[i]); else n_pass++;
      n_checks++;
      if (bus.count !== 5'(2 - i)) $display("FAIL basic_cnt%0d got=%0d want=%0d", i, bus.count, 2 - i);
      else n_pass++;
    end
    n_checks++;
    if (bus.rempty !== 1'b1) $display("FAIL basic_empty got=%b want=1", bus.rempty); else n_pass++;
  endtask

  task automatic test_full();
    logic p; logic [WIDTH-1:0] g, e;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, p, g, e);
    n_checks++;
    if (bus.wfull !== 1'b1 || bus.count !== 5'd16)
      $display("FAIL full_flag got f=%b c=%0d want f=1 c=16", bus.wfull, bus.count);
    else n_pass++;
    cycle(1'b1, 8'hAA, 1'b0, p, g, e);
    n_checks++;
    if (bus.wfull !== 1'b1 || bus.count !== 5'd16 || bus.rempty !== 1'b0)
      $display("FAIL full_overflow got f=%b c=%0d e=%b want f=1 c=16 e=0",
               bus.wfull, bus.count, bus.rempty);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, p, g, e);
      n_checks++;
      if (g !== 8'(i)) $display("FAIL full_read%0d got=%h want=%h", i, g, 8'(i)); else n_pass++;
    end
    n_checks++;
    if (bus.rempty !== 1'b1 || bus.count !== 5'd0)
      $display("FAIL full_drain got e=%b c=%0d want e=1 c=0", bus.rempty, bus.count);
    else n_pass++;
  endtask

  task automatic test_empty_read();
    logic p; logic [WIDTH-1:0] g, e;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, p, g, e);
      n_checks++;
      if (bus.rempty !== 1'b1 || bus.count !== 5'd0 || bus.wfull !== 1'b0)
        $display("FAIL empty_read%0d got e=%b c=%0d f=%b want e=1 c=0 f=0",
                 i, bus.rempty, bus.count, bus.wfull);
      else n_pass++;
    end
    // An unmoved read pointer means the next written word is the next head.
    cycle(1'b1, 8'hC3, 1'b0, p, g, e);
    n_checks++;
    if (bus.rdata !== 8'hC3 || bus.count !== 5'd1)
      $display("FAIL empty_then_write got d=%h c=%0d want d=c3 c=1", bus.rdata, bus.count);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, p, g, e);
  endtask

  task automatic test_simul_edges();
    logic p; logic [WIDTH-1:0] g, e;
    cycle(1'b1, 8'h3C, 1'b1, p, g, e);
    n_checks++;
    if (bus.count !== 5'd1 || bus.rdata !== 8'h3C)
      $display("FAIL simul_empty got c=%0d d=%h want c=1 d=3c", bus.count, bus.rdata);
    else n_pass++;
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, p, g, e);
    cycle(1'b1, 8'hEE, 1'b1, p, g, e);
    n_checks++;
    if (bus.count !== 5'd15 || bus.wfull !== 1'b0 || g !== 8'h3C)
      $display("FAIL simul_full got c=%0d f=%b d=%h want c=15 f=0 d=3c", bus.count, bus.wfull, g);
    else n_pass++;
    while (model.size() > 0) begin
      cycle(1'b0, 8'h00, 1'b1, p, g, e);
      n_checks++;
      if (g !== e) $display("FAIL simul_drain got=%h want=%h", g, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic p; logic [WIDTH-1:0] g, e;
    logic [WIDTH-1:0] pat;
    pat = 8'h80;
    for (int i = 0; i < 8; i++) begin cycle(1'b1, pat, 1'b0, p, g, e); pat++; end
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, pat, 1'b1, p, g, e);
      pat++;
      n_checks++;
      if (g !== e || bus.count !== 5'd8)
        $display("FAIL b2b_%0d got d=%h c=%0d want d=%h c=8", i, g, bus.count, e);
      else n_pass++;
    end
    while (model.size() > 0) cycle(1'b0, 8'h00, 1'b1, p, g, e);
  endtask

  task automatic test_random();
    logic p; logic [WIDTH-1:0] g, e;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < (i < 200 ? 70 : 30)), 8'($urandom),
            1'($urandom_range(0, 99) < 50), p, g, e);
      n_checks++;
      if ((p && g !== e) || bus.count !== 5'(model.size())
          || bus.rempty !== (model.size() == 0) || bus.wfull !== (model.size() == DEPTH)
          || (bus.rempty && bus.wfull))
        $display("FAIL rand_%0d got d=%h c=%0d e=%b f=%b want d=%h c=%0d", i, g,
                 bus.count, bus.rempty, bus.wfull, e, model.size());
      else n_pass++;
    end
    while (model.size() > 0) cycle(1'b0, 8'h00, 1'b1, p, g, e);
  endtask

  task automatic test_async_reset();
    logic p; logic [WIDTH-1:0] g, e;
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, p, g, e);
    #2 wrst = 1'b1;
    #1;
    n_checks++;
    if (bus.rempty !== 1'b1 || bus.count !== 5'd0 || bus.wfull !== 1'b0)
      $display("FAIL async_rst got e=%b c=%0d f=%b want e=1 c=0 f=0",
               bus.rempty, bus.count, bus.wfull);
    else n_pass++;
    model.delete();
    bus.winc = 1'b1; bus.wdata = 8'h99;
    @(posedge wclk);
    #3 wrst = 1'b0; bus.winc = 1'b0;
    #1;
    n_checks++;
    if (bus.rempty !== 1'b1 || bus.count !== 5'd0 || bus.rdata !== 8'h00)
      $display("FAIL async_rst_after got e=%b c=%0d d=%h want e=1 c=0 d=00",
               bus.rempty, bus.count, bus.rdata);
    else n_pass++;
    @(posedge wclk); #1;
    cycle(1'b1, 8'h5A, 1'b0, p, g, e);
    cycle(1'b0, 8'h00, 1'b1, p, g, e);
    n_checks++;
    if (!p || g !== 8'h5A || bus.rempty !== 1'b1)
      $display("FAIL async_rst_resume got p=%b d=%h e=%b want p=1 d=5a e=1", p, g, bus.rempty);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    wrst      = 1'b1;
    bus.winc  = 1'b0;
    bus.wdata = '0;
    bus.rinc  = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_empty_read();
    test_simul_edges();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
